// File: rtl/hamming_decoder_if.sv
// Bus between a Hamming(7,4) decoder and its user: codeword request in,
// corrected data, error report and status out.
interface hamming_decoder_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             mode;
    logic [6:0]       data_in;
    logic [3:0]       data_out;
    logic             err;
    logic [2:0]       err_pos;
    logic [CNT_W-1:0] err_count;
    logic             busy;
    logic             done;

    modport master (
        output enable, mode, data_in,
        input  data_out, err, err_pos, err_count, busy, done
    );

    modport slave (
        input  enable, mode, data_in,
        output data_out, err, err_pos, err_count, busy, done
    );
endinterface

// File: rtl/hamming_decoder.sv
// Serial Hamming(7,4) single-error-correcting decoder: one parity check per
// cycle, then correction, error reporting and a saturating corrected-word count.
module hamming_decoder #(
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    hamming_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        S1   = 3'b001,
        S2   = 3'b010,
        S4   = 3'b100,
        DONE = 3'b111
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic [6:0] cw_q;
    logic       mode_q;
    logic       s1_q;
    logic       s2_q;
    logic       s4_q;
    logic [2:0] syn;
    logic [6:0] flip_mask;
    logic [6:0] corrected;

    assign syn = {s4_q, s2_q, s1_q};

    // The syndrome is the 1-based position of the bad bit; zero means clean.
    always_comb begin
        flip_mask = '0;
        if (syn != 3'd0) begin
            flip_mask[syn - 3'd1] = 1'b1;
        end
    end

    assign corrected = cw_q ^ flip_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cw_q          <= '0;
            mode_q        <= 1'b0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s4_q          <= 1'b0;
            bus.data_out  <= '0;
            bus.err       <= 1'b0;
            bus.err_pos   <= '0;
            bus.err_count <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        cw_q     <= bus.data_in;
                        mode_q   <= bus.mode;
                        bus.busy <= 1'b1;
                        state    <= S1;
                    end
                end
                // Odd parity is handled by inverting each check when mode_q=0.
                S1: begin
                    s1_q  <= cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6] ^ ~mode_q;
                    state <= S2;
                end
                S2: begin
                    s2_q  <= cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6] ^ ~mode_q;
                    state <= S4;
                end
                S4: begin
                    s4_q  <= cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6] ^ ~mode_q;
                    state <= DONE;
                end
                DONE: begin
                    bus.data_out <= {corrected[6], corrected[5], corrected[4], corrected[2]};
                    bus.err      <= (syn != 3'd0);
                    bus.err_pos  <= syn;
                    bus.done     <= 1'b1;
                    if ((syn != 3'd0) && (bus.err_count != CNT_MAX)) begin
                        bus.err_count <= bus.err_count + 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                // Recover from a corrupted state register without touching outputs.
                default: begin
                    s1_q     <= 1'b0;
                    s2_q     <= 1'b0;
                    s4_q     <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: hand-computed codewords, latency,
// streaming, mid-word reset and counter saturation on a narrow instance.
module tb_hamming_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hamming_decoder_if #(.CNT_W(8)) bus ();
    hamming_decoder_if #(.CNT_W(2)) sat_bus ();

    hamming_decoder #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    hamming_decoder #(.CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One word: enable for one edge, scramble inputs while busy, check timing and result.
    task automatic applyStimulus(input bit sat, input logic [6:0] word, input logic m,
                                 input logic [3:0] exp_data, input logic exp_err,
                                 input logic [2:0] exp_pos, input int exp_cnt, input string tag);
        @(negedge clk);
        if (sat) begin
            sat_bus.data_in = word; sat_bus.mode = m; sat_bus.enable = 1'b1;
        end else begin
            bus.data_in = word; bus.mode = m; bus.enable = 1'b1;
        end
        @(posedge clk); #1;
        if (sat) begin
            sat_bus.enable = 1'b0; sat_bus.data_in = ~word; sat_bus.mode = ~m;
        end else begin
            bus.enable = 1'b0; bus.data_in = ~word; bus.mode = ~m;
        end
        checkOutput({tag, "_busy"}, sat ? sat_bus.busy : bus.busy, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_done_e3"}, sat ? sat_bus.done : bus.done, 0);
        @(posedge clk); #1;
        checkOutput({tag, "_done_e4"}, sat ? sat_bus.done : bus.done, 1);
        checkOutput({tag, "_data"}, sat ? sat_bus.data_out : bus.data_out, exp_data);
        checkOutput({tag, "_err"}, sat ? sat_bus.err : bus.err, exp_err);
        checkOutput({tag, "_pos"}, sat ? sat_bus.err_pos : bus.err_pos, exp_pos);
        checkOutput({tag, "_count"}, sat ? 32'(sat_bus.err_count) : 32'(bus.err_count), exp_cnt);
        @(posedge clk); #1;
        checkOutput({tag, "_done_e5"}, sat ? sat_bus.done : bus.done, 0);
    endtask

    initial begin
        logic [6:0] good;
        logic [6:0] junk;
        int         pulses;
        bit         done_seen;

        good = 7'b0110011;
        junk = 7'b1111000;
        bus.enable = 1'b0; bus.mode = 1'b0; bus.data_in = '0;
        sat_bus.enable = 1'b0; sat_bus.mode = 1'b0; sat_bus.data_in = '0;

        #1 rst = 1'b1;
        #4;
        checkOutput("rst_data", bus.data_out, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_pos", bus.err_pos, 0);
        checkOutput("rst_count", bus.err_count, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_busy", bus.busy, 0);
        @(negedge clk) rst = 1'b0;

        applyStimulus(0, 7'b1010101, 1'b1, 4'b1011, 1'b0, 3'd0, 0, "t1_clean_even");
        applyStimulus(0, 7'b1000101, 1'b1, 4'b1011, 1'b1, 3'd5, 1, "t2_pos5");
        applyStimulus(0, 7'b1011110, 1'b0, 4'b1011, 1'b0, 3'd0, 1, "t3_clean_odd");
        applyStimulus(0, 7'b1011111, 1'b0, 4'b1011, 1'b1, 3'd1, 2, "t3_odd_p1");
        applyStimulus(0, 7'b0010101, 1'b1, 4'b1011, 1'b1, 3'd7, 3, "pos7");
        applyStimulus(0, 7'b1010001, 1'b1, 4'b1011, 1'b1, 3'd3, 4, "pos3");
        applyStimulus(0, 7'b0110011, 1'b1, 4'b0110, 1'b0, 3'd0, 4, "clean_0110");
        applyStimulus(0, 7'b0010011, 1'b1, 4'b0110, 1'b1, 3'd6, 5, "pos6");
        applyStimulus(0, 7'b0111011, 1'b1, 4'b0110, 1'b1, 3'd4, 6, "pos4_parity");
        applyStimulus(0, 7'b1010110, 1'b1, 4'b1010, 1'b1, 3'd3, 7, "double_miscorrect");

        // Enable held high: captures at E0, E5, E10 only; junk between captures.
        @(negedge clk);
        bus.data_in = good; bus.mode = 1'b1; bus.enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
            checkOutput($sformatf("t4_done_e%0d", i), bus.done, ((i == 4) || (i == 9)));
            if ((i == 4) || (i == 9)) begin
                checkOutput($sformatf("t4_data_e%0d", i), bus.data_out, 4'b0110);
                checkOutput($sformatf("t4_err_e%0d", i), bus.err, 0);
            end
            bus.data_in = (i % 5 == 4) ? good : junk;
        end
        bus.enable = 1'b0;
        checkOutput("t4_pulses", pulses, 2);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t4_count", bus.err_count, 7);

        // Reset while the decoder sits in S2.
        @(negedge clk);
        bus.data_in = 7'b1000101; bus.mode = 1'b1; bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_data", bus.data_out, 0);
        checkOutput("t5_err", bus.err, 0);
        checkOutput("t5_pos", bus.err_pos, 0);
        checkOutput("t5_count", bus.err_count, 0);
        checkOutput("t5_busy", bus.busy, 0);
        @(negedge clk) rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
        end
        checkOutput("t5_no_done", done_seen, 0);
        applyStimulus(0, 7'b1000101, 1'b1, 4'b1011, 1'b1, 3'd5, 1, "t5_after");

        applyStimulus(1, 7'b1000101, 1'b1, 4'b1011, 1'b1, 3'd5, 1, "t6_sat1");
        applyStimulus(1, 7'b1000101, 1'b1, 4'b1011, 1'b1, 3'd5, 2, "t6_sat2");
        applyStimulus(1, 7'b0010011, 1'b1, 4'b0110, 1'b1, 3'd6, 3, "t6_sat3");
        applyStimulus(1, 7'b1000101, 1'b1, 4'b1011, 1'b1, 3'd5, 3, "t6_sat4");
        applyStimulus(1, 7'b1011111, 1'b0, 4'b1011, 1'b1, 3'd1, 3, "t6_sat5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
